map_rom_arbiter: RTL and testbench
==================================

Name: map_rom_arbiter

Overview:
Shares the single read port of the collision/level map ROM between up to N_REQ game-logic requesters: player Y control, player X control, enemy control and the map draw path. It uses fair round-robin arbitration with at most one grant per cycle, and runs fully pipelined. It tags each issued read and routes the returned pixel back to the winning requester with a fixed latency. It also substitutes a "solid" value for out-of-range addresses, so no requester ever reads past the map.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDR_W, 16, map ROM address width
DATA_W, 12, map pixel width (RGB444)
RD_LAT, 1, ROM read latency in cycles from rom_adr to rom_data (1..3)
MAP_DEPTH, 65536, number of valid ROM words; addresses >= MAP_DEPTH are out of range
OOB_DATA, 12'h000, value returned for out-of-range reads (treated as solid by all requesters)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
req  input  N_REQ  per-requester read request; held high until gnt
req_adr  input  N_REQ*ADDR_W  flattened addresses; slice i = requester i; stable while req[i] high
gnt  output  N_REQ  one-hot combinational grant; the request is consumed in the cycle gnt[i]=1
rd_valid  output  N_REQ  one-hot pulse; rd_data is valid for requester i
rd_data  output  DATA_W  returned pixel, shared by all requesters; qualified by rd_valid
rom_adr  output  ADDR_W  registered address to the map ROM
rom_data  input  DATA_W  ROM read data, RD_LAT cycles after rom_adr

Behaviour:
- Reset values: gnt=0, rd_valid=0, rd_data=0, rom_adr=0, last_winner=N_REQ-1 (so requester 0 has top priority first), tag pipeline cleared.
- Arbitration (combinational, same cycle as req):
  - Search order starts at (last_winner+1) mod N_REQ and wraps.
  - The first requester found with req[i]=1 wins and gets gnt[i]=1.
  - No req means gnt=0 and last_winner is unchanged.
- On a grant edge:
  - last_winner <= i.
  - rom_adr <= req_adr[i] if in range, else rom_adr <= 0.
  - Tag stage 0 <= {valid=1, id=i, oob=(req_adr[i] >= MAP_DEPTH)}.
  - With no grant, tag stage 0 valid=0 and rom_adr holds its value.
- Tag pipeline is 1+RD_LAT stages deep (shift register). At the last stage:
  - rd_valid[id]=valid.
  - rd_data = oob ? OOB_DATA : rom_data (combinational mux on rom_data).
  - rd_data holds its last value when valid=0.
- Latency: gnt cycle t gives rd_valid at cycle t+1+RD_LAT. The default is 2 cycles.
- Throughput: one grant per cycle. A requester that keeps req high after gnt is granted again only after every other active requester has been granted once. Worst-case wait is N_REQ-1 cycles.
- Back-to-back reads from different requesters return in grant order; returns never reorder.
- A req drop without gnt is legal (request withdrawn); no read is issued.
- Simultaneous events: a new grant and a rd_valid may occur in the same cycle, including for the same requester.
- Reset mid-operation: all in-flight tags are discarded; no rd_valid after reset even if the ROM returns data.
- Address width rule: the comparison against MAP_DEPTH is unsigned on ADDR_W+1 bits, so MAP_DEPTH=2^ADDR_W never flags out-of-range.

Decomposition:
- Package map_rom_pkg holds:
  - MAP_ADDR_W, MAP_DATA_W, MAP_DEPTH, MAP_OOB_DATA.
  - Requester index constants REQ_PLAYER_Y=0, REQ_PLAYER_X=1, REQ_ENEMY=2, REQ_DRAW=3.
  - Tag struct typedef {valid, id, oob}.
- Sub-module rr_pick: combinational round-robin picker (inputs req and last_winner; outputs one-hot gnt and winner index). It is instantiated once.

Test Plan:
- Reset then a single request: req=4'b0001, req_adr[0]=16'h1234. Required: gnt=4'b0001 same cycle, rom_adr=16'h1234 next cycle, rd_valid=4'b0001 with rd_data=ROM[16'h1234] 2 cycles after gnt.
- All four requesting continuously from reset. Required: gnt sequence 0,1,2,3,0,1,...; rd_valid follows the same sequence 2 cycles later; each rd_data matches its own requester's address.
- Fairness with req=4'b1010 held for 6 cycles after last_winner=3. Required: gnt alternates 1,3,1,3,1,3; requesters 0 and 2 are never granted.
- Out-of-range read with MAP_DEPTH=1000, req_adr[2]=1000. Required: rom_adr=0, rd_valid[2] after 2 cycles, rd_data=12'h000 regardless of ROM content. A read with address 999 returns ROM[999].
- Reset asserted 1 cycle after gnt[1]. Required: rd_valid stays 0 for all subsequent cycles until a new grant; the next grant goes to requester 0 first.
- Withdrawn request: req[3] high 1 cycle while requester 0 wins, then drops. Required: no rd_valid[3] ever; last_winner=0.

Source files
------------

// File: rtl/map_rom_arbiter_pkg.sv
// Shared constants, requester indices and the read-tag record for the map ROM arbiter.
package map_rom_pkg;

  localparam int MAP_ADDR_W = 16;
  localparam int MAP_DATA_W = 12;
  localparam int MAP_DEPTH  = 65536;
  localparam logic [MAP_DATA_W-1:0] MAP_OOB_DATA = 12'h000;

  // Tag ids are sized for the largest supported requester count (8).
  localparam int MAP_ID_W = 3;

  localparam int REQ_PLAYER_Y = 0;
  localparam int REQ_PLAYER_X = 1;
  localparam int REQ_ENEMY    = 2;
  localparam int REQ_DRAW     = 3;

  typedef struct packed {
    logic                valid;
    logic [MAP_ID_W-1:0] id;
    logic                oob;
  } map_tag_t;

endpackage

// File: rtl/map_rom_arbiter_if.sv
// Bundle of requester-side and ROM-side signals around the map ROM arbiter.
interface map_rom_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 12
) ();

  // req[i] is held with a stable req_adr slice until gnt[i]; the request is consumed
  // in the cycle gnt[i]=1. rd_valid[i] is a one-cycle pulse qualifying rd_data; there
  // is no backpressure on the return path. rom_data follows rom_adr by RD_LAT cycles.
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_adr;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]       rd_data;
  logic [ADDR_W-1:0]       rom_adr;
  logic [DATA_W-1:0]       rom_data;

  modport master (
    output req, req_adr, rom_data,
    input  gnt, rd_valid, rd_data, rom_adr
  );

  modport slave (
    input  req, req_adr, rom_data,
    output gnt, rd_valid, rd_data, rom_adr
  );

endinterface

// File: rtl/map_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request after the last winner wins.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0] o_win,
  output logic             o_any
);

  int w_idx;

  always_comb begin
    o_gnt = '0;
    o_win = '0;
    o_any = 1'b0;
    w_idx = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = int'(i_last) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (!o_any && i_req[w_idx]) begin
        o_any        = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_win        = IDX_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/map_rom_arbiter.sv
// Round-robin sharing of the map ROM read port with tagged, fixed-latency returns
// and out-of-range substitution.
module map_rom_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = map_rom_pkg::MAP_ADDR_W,
  parameter int DATA_W    = map_rom_pkg::MAP_DATA_W,
  parameter int RD_LAT    = 1,
  parameter int MAP_DEPTH = map_rom_pkg::MAP_DEPTH,
  parameter logic [DATA_W-1:0] OOB_DATA = map_rom_pkg::MAP_OOB_DATA
) (
  input  logic                              clk,
  input  logic                              rst,
  map_rom_arbiter_if.slave                  bus,
  output logic [map_rom_pkg::MAP_ID_W-1:0]  o_last_winner
);
  import map_rom_pkg::*;

  localparam int IDX_W = $clog2(N_REQ);
  // One extra bit so a depth of 2^ADDR_W never flags an address as out of range.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(MAP_DEPTH);

  logic [IDX_W-1:0]  r_last_winner;
  logic [ADDR_W-1:0] r_rom_adr;
  logic [DATA_W-1:0] r_rd_data;
  map_tag_t          r_tag [0:RD_LAT];

  logic [N_REQ-1:0]  w_gnt;
  logic [IDX_W-1:0]  w_win;
  logic              w_any;
  logic [ADDR_W-1:0] w_sel_adr;
  logic              w_oob;
  map_tag_t          w_tag_in;
  map_tag_t          w_last;
  logic [DATA_W-1:0] w_data_now;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req  (bus.req),
    .i_last (r_last_winner),
    .o_gnt  (w_gnt),
    .o_win  (w_win),
    .o_any  (w_any)
  );

  assign w_sel_adr = bus.req_adr[int'(w_win)*ADDR_W +: ADDR_W];
  assign w_oob     = ({1'b0, w_sel_adr} >= DEPTH_C);

  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = w_any;
    w_tag_in.id    = MAP_ID_W'(w_win);
    w_tag_in.oob   = w_any & w_oob;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_winner <= IDX_W'(N_REQ-1);
      r_rom_adr     <= '0;
    end else if (w_any) begin
      r_last_winner <= w_win;
      r_rom_adr     <= w_oob ? '0 : w_sel_adr;
    end
  end

  // Tag shift register lines each grant up with its rom_data beat RD_LAT cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s <= RD_LAT; s++) r_tag[s] <= '0;
    end else begin
      r_tag[0] <= w_tag_in;
      for (int s = 1; s <= RD_LAT; s++) r_tag[s] <= r_tag[s-1];
    end
  end

  assign w_last     = r_tag[RD_LAT];
  assign w_data_now = w_last.oob ? OOB_DATA : bus.rom_data;

  always_ff @(posedge clk) begin
    if (rst)              r_rd_data <= '0;
    else if (w_last.valid) r_rd_data <= w_data_now;
  end

  assign bus.gnt       = w_gnt;
  assign bus.rom_adr   = r_rom_adr;
  assign bus.rd_valid  = w_last.valid ? (N_REQ'(1) << w_last.id) : '0;
  assign bus.rd_data   = w_last.valid ? w_data_now : r_rd_data;
  assign o_last_winner = MAP_ID_W'(r_last_winner);

endmodule

// File: tb/tb_map_rom_arbiter.sv
// Directed bench for map_rom_arbiter: full-depth DUT plus a MAP_DEPTH=1000 DUT on shared stimulus.
module tb_map_rom_arbiter;
  import map_rom_pkg::*;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    r_req = '0;
  logic [N*AW-1:0] r_adr = '0;
  logic [MAP_ID_W-1:0] last_a, last_b;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  map_rom_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus_a ();
  map_rom_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus_b ();

  assign bus_a.req     = r_req;
  assign bus_a.req_adr = r_adr;
  assign bus_b.req     = r_req;
  assign bus_b.req_adr = r_adr;

  map_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .MAP_DEPTH(65536))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a), .o_last_winner(last_a));
  map_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .MAP_DEPTH(1000))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b), .o_last_winner(last_b));

  // Clock / ROM models
  always #5 clk = ~clk;

  function automatic logic [11:0] rom_fn(input logic [15:0] a);
    return a[11:0] ^ {a[15:12], a[15:12], a[15:12]} ^ 12'h5A3;
  endfunction

  always_ff @(posedge clk) bus_a.rom_data <= rom_fn(bus_a.rom_adr);
  always_ff @(posedge clk) bus_b.rom_data <= rom_fn(bus_b.rom_adr);

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Driver / checker tasks
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_adr(input int i, input logic [15:0] a);
    r_adr[i*AW +: AW] = a;
  endtask

  task automatic prime();
    exp_q.delete();
    exp_q.push_back(16'h0);
    exp_q.push_back(16'h0);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    r_req = '0;
    step();
    step();
    rst = 1'b0;
    prime();
  endtask

  // One cycle on dut_a: check the grant now and the return due from two cycles back.
  task automatic tick(input logic [3:0] exp_gnt);
    logic [15:0] e;
    logic [15:0] a;
    a = 16'h0;
    @(negedge clk);
    chk("gnt", 32'(bus_a.gnt), 32'(exp_gnt));
    for (int i = 0; i < N; i++) if (exp_gnt[i]) a = r_adr[i*AW +: AW];
    exp_q.push_back({exp_gnt, (exp_gnt != 4'b0) ? rom_fn(a) : 12'h000});
    e = exp_q.pop_front();
    chk("rd_valid", 32'(bus_a.rd_valid), 32'(e[15:12]));
    if (e[15:12] != 4'b0) chk("rd_data", 32'(bus_a.rd_data), 32'(e[11:0]));
    step();
  endtask

  initial begin
    r_req = '0;
    r_adr = '0;
    do_reset();

    // Reset values
    chk("rst_gnt",      32'(bus_a.gnt), 0);
    chk("rst_rd_valid", 32'(bus_a.rd_valid), 0);
    chk("rst_rd_data",  32'(bus_a.rd_data), 0);
    chk("rst_rom_adr",  32'(bus_a.rom_adr), 0);
    chk("rst_last",     32'(last_a), 3);

    // Single request from requester 0
    set_adr(0, 16'h1234);
    r_req = 4'b0001;
    tick(4'b0001);
    r_req = '0;
    chk("t1_rom_adr", 32'(bus_a.rom_adr), 32'h1234);
    tick(4'b0000);
    tick(4'b0000);
    tick(4'b0000);

    // All four requesting continuously from reset
    set_adr(0, 16'h0A10);
    set_adr(1, 16'h0B21);
    set_adr(2, 16'h0C32);
    set_adr(3, 16'hDD43);
    do_reset();
    r_req = 4'b1111;
    for (int c = 0; c < 8; c++) tick(4'b0001 << (c % 4));
    r_req = '0;
    tick(4'b0000);
    tick(4'b0000);
    chk("t2_last", 32'(last_a), 3);

    // Fairness between requesters 1 and 3
    r_req = 4'b1010;
    for (int c = 0; c < 6; c++) tick((c % 2 == 0) ? 4'b0010 : 4'b1000);
    r_req = '0;
    tick(4'b0000);
    tick(4'b0000);

    // Out-of-range on the MAP_DEPTH=1000 instance, and the boundary below it
    set_adr(2, 16'd1000);
    r_req = 4'b0100;
    tick(4'b0100);
    r_req = '0;
    chk("oob_rom_adr_b", 32'(bus_b.rom_adr), 0);
    chk("inr_rom_adr_a", 32'(bus_a.rom_adr), 1000);
    tick(4'b0000);
    chk("oob_valid_b", 32'(bus_b.rd_valid), 32'b0100);
    chk("oob_data_b",  32'(bus_b.rd_data), 0);
    tick(4'b0000);

    set_adr(2, 16'd999);
    r_req = 4'b0100;
    tick(4'b0100);
    r_req = '0;
    chk("edge_rom_adr_b", 32'(bus_b.rom_adr), 999);
    tick(4'b0000);
    chk("edge_valid_b", 32'(bus_b.rd_valid), 32'b0100);
    chk("edge_data_b",  32'(bus_b.rd_data), 32'(rom_fn(16'd999)));
    tick(4'b0000);

    set_adr(2, 16'hFFFF);
    r_req = 4'b0100;
    tick(4'b0100);
    r_req = '0;
    chk("top_rom_adr_a", 32'(bus_a.rom_adr), 32'hFFFF);
    chk("top_rom_adr_b", 32'(bus_b.rom_adr), 0);
    tick(4'b0000);
    tick(4'b0000);

    // Same requester held: new grant and its own return in the same cycle
    set_adr(2, 16'h0456);
    r_req = 4'b0100;
    for (int c = 0; c < 3; c++) tick(4'b0100);
    r_req = '0;
    tick(4'b0000);
    tick(4'b0000);

    // Reset one cycle after a grant to requester 1 discards the in-flight read
    set_adr(1, 16'h0222);
    r_req = 4'b0010;
    tick(4'b0010);
    rst   = 1'b1;
    r_req = '0;
    @(negedge clk);
    chk("rst_mid_rv", 32'(bus_a.rd_valid), 0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("rst_after_rv_a", 32'(bus_a.rd_valid), 0);
      chk("rst_after_rv_b", 32'(bus_b.rd_valid), 0);
      chk("rst_after_last", 32'(last_a), 3);
      step();
    end

    // Requester 0 wins first; requester 3 withdraws without a grant
    prime();
    set_adr(3, 16'h0333);
    r_req = 4'b1001;
    tick(4'b0001);
    r_req = '0;
    chk("wd_last0", 32'(last_a), 0);
    tick(4'b0000);
    tick(4'b0000);
    tick(4'b0000);
    chk("wd_last1", 32'(last_a), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
